// File: rtl/board_reset_pkg.sv
// Shared definitions for the board reset sequencer: state encoding, status LED
// bit positions and the saturating lock-loss increment.
package board_reset_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LOCK = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } seq_state_e;

    localparam int LED_HEARTBEAT = 0;
    localparam int LED_NPOR      = 1;
    localparam int LED_LOCKED    = 2;
    localparam int LED_GRST      = 3;
    localparam int LED_STATE_LSB = 4;
    localparam int LED_STATE_MSB = 5;
    localparam int LED_LOSS_LSB  = 6;
    localparam int LED_LOSS_MSB  = 7;

    localparam int LOSS_W = 2;

    function automatic logic [LOSS_W-1:0] sat_inc_loss(input logic [LOSS_W-1:0] value);
        logic [LOSS_W-1:0] result;
        result = (value == {LOSS_W{1'b1}}) ? value : value + 1'b1;
        return result;
    endfunction

endpackage

// File: rtl/board_reset_seq_if.sv
// Board-side signals of the reset sequencer: asynchronous status inputs in,
// generated reset and status indications out.
interface board_reset_seq_if;

    logic       npor;
    logic       pll_locked;
    logic       global_reset_n;
    logic [1:0] seq_state;
    logic [7:0] leds;

    modport master (
        output npor,
        output pll_locked,
        input  global_reset_n,
        input  seq_state,
        input  leds
    );

    modport slave (
        input  npor,
        input  pll_locked,
        output global_reset_n,
        output seq_state,
        output leds
    );

endinterface

// File: rtl/reset_sync_2ff.sv
// Two-flop synchronizer bringing one asynchronous level into the clk domain;
// the asynchronous clear forces the synchronized output low.
module reset_sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/board_reset_seq.sv
// Board reset sequencer: waits for PCIe npor and a filtered PLL lock, holds the
// system in reset for HOLD_CYCLES, then releases global_reset_n.
module board_reset_seq
    import board_reset_pkg::*;
#(
    parameter int HOLD_CYCLES = 1024,
    parameter int LOCK_FILTER = 16,
    parameter int HB_DIV_LOG2 = 25
) (
    input  logic               config_clk,
    input  logic               resetn,
    board_reset_seq_if.slave   bus
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES);
    localparam int LOCK_W = (LOCK_FILTER > 1) ? $clog2(LOCK_FILTER) : 1;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_FILTER - 1);

    // Index 0 carries npor, index 1 carries pll_locked.
    logic [1:0] async_in;
    logic [1:0] sync_out;
    logic       npor_s;
    logic       locked_s;

    seq_state_e              state_reg;
    seq_state_e              state_next;
    logic [LOCK_W-1:0]       lock_cnt_reg;
    logic [LOCK_W-1:0]       lock_cnt_next;
    logic [HOLD_W-1:0]       hold_cnt_reg;
    logic [HOLD_W-1:0]       hold_cnt_next;
    logic [LOSS_W-1:0]       loss_cnt_reg;
    logic [LOSS_W-1:0]       loss_cnt_next;
    logic [HB_DIV_LOG2-1:0]  hb_cnt_reg;
    logic                    grst_n_reg;
    logic [7:0]              leds_next;

    assign async_in = {bus.pll_locked, bus.npor};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            reset_sync_2ff u_sync (
                .clk   (config_clk),
                .rst_n (resetn),
                .d     (async_in[gi]),
                .q     (sync_out[gi])
            );
        end
    endgenerate

    assign npor_s   = sync_out[0];
    assign locked_s = sync_out[1];

    always_ff @(posedge config_clk or negedge resetn) begin
        if (!resetn) begin
            state_reg    <= IDLE;
            lock_cnt_reg <= '0;
            hold_cnt_reg <= '0;
            loss_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            lock_cnt_reg <= lock_cnt_next;
            hold_cnt_reg <= hold_cnt_next;
            loss_cnt_reg <= loss_cnt_next;
        end
    end

    // Counters default to zero so any state exit (or npor loss) leaves them
    // cleared; they only advance while their own state is being held.
    always_comb begin
        state_next    = state_reg;
        lock_cnt_next = '0;
        hold_cnt_next = '0;
        loss_cnt_next = loss_cnt_reg;

        if (!npor_s) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_next = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    if (locked_s) begin
                        if (lock_cnt_reg == LOCK_LAST) begin
                            state_next = HOLD;
                        end else begin
                            lock_cnt_next = lock_cnt_reg + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (!locked_s) begin
                        state_next    = WAIT_LOCK;
                        loss_cnt_next = sat_inc_loss(loss_cnt_reg);
                    end else if (hold_cnt_reg == HOLD_LAST) begin
                        state_next = RUN;
                    end else begin
                        hold_cnt_next = hold_cnt_reg + 1'b1;
                    end
                end
                RUN: begin
                    if (!locked_s) begin
                        state_next    = WAIT_LOCK;
                        loss_cnt_next = sat_inc_loss(loss_cnt_reg);
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Decoded from state_next so the flop tracks the RUN state cycle-for-cycle
    // while still coming straight off a register.
    always_ff @(posedge config_clk or negedge resetn) begin
        if (!resetn) begin
            grst_n_reg <= 1'b0;
        end else begin
            grst_n_reg <= (state_next == RUN);
        end
    end

    always_ff @(posedge config_clk or negedge resetn) begin
        if (!resetn) begin
            hb_cnt_reg <= '0;
        end else begin
            hb_cnt_reg <= hb_cnt_reg + 1'b1;
        end
    end

    always_comb begin
        leds_next                              = '0;
        leds_next[LED_HEARTBEAT]               = hb_cnt_reg[HB_DIV_LOG2-1];
        leds_next[LED_NPOR]                    = npor_s;
        leds_next[LED_LOCKED]                  = locked_s;
        leds_next[LED_GRST]                    = grst_n_reg;
        leds_next[LED_STATE_MSB:LED_STATE_LSB] = state_reg;
        leds_next[LED_LOSS_MSB:LED_LOSS_LSB]   = loss_cnt_reg;
    end

    assign bus.global_reset_n = grst_n_reg;
    assign bus.seq_state      = state_reg;
    assign bus.leds           = leds_next;

endmodule

// File: tb/tb_board_reset_seq.sv
// Directed and randomized checks of board_reset_seq against a timestamp-based
// reference model of the reset sequence.
module tb_board_reset_seq;

    localparam int LF = 4;
    localparam int HC = 8;
    localparam int HB = 4;

    logic config_clk = 1'b0;
    logic resetn     = 1'b0;

    board_reset_seq_if bus ();

    board_reset_seq #(
        .HOLD_CYCLES (HC),
        .LOCK_FILTER (LF),
        .HB_DIV_LOG2 (HB)
    ) dut (
        .config_clk (config_clk),
        .resetn     (resetn),
        .bus        (bus)
    );

    always #5 config_clk = ~config_clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: the synchronized inputs are the raw inputs seen two
    // edges earlier; lock qualification and hold expiry are tracked as times.
    int cyc = 0;
    bit m_np1, m_np2, m_lk1, m_lk2;
    int m_state;
    int m_streak_start;
    int m_hold_start;
    int m_loss;
    int m_hb;
    bit m_grn;

    int fw, fh, fr;
    int rise_at, fall_at;

    function automatic void model_reset();
        m_np1 = 0; m_np2 = 0; m_lk1 = 0; m_lk2 = 0;
        m_state = 0;
        m_streak_start = -1;
        m_hold_start = 0;
        m_loss = 0;
        m_hb = 0;
        m_grn = 0;
    endfunction

    function automatic void model_step();
        int nxt;
        if (!resetn) begin
            model_reset();
            return;
        end
        nxt = m_state;
        if (!m_np2) begin
            nxt = 0;
        end else if (m_state == 0) begin
            nxt = 1;
        end else if ((m_state == 2 || m_state == 3) && !m_lk2) begin
            nxt = 1;
            if (m_loss < 3) m_loss++;
        end else if (m_state == 1) begin
            if (m_lk2) begin
                if (m_streak_start < 0) m_streak_start = cyc;
                if (cyc - m_streak_start + 1 >= LF) begin
                    nxt = 2;
                    m_hold_start = cyc + 1;
                end
            end else begin
                m_streak_start = -1;
            end
        end else if (m_state == 2) begin
            if (cyc - m_hold_start + 1 >= HC) nxt = 3;
        end
        if (nxt != 1) m_streak_start = -1;
        m_state = nxt;
        m_grn   = (nxt == 3);
        m_hb    = (m_hb + 1) % (1 << HB);
        m_np2   = m_np1;
        m_np1   = bus.npor;
        m_lk2   = m_lk1;
        m_lk1   = bus.pll_locked;
        cyc++;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [31:0] ls;
        logic [31:0] hb;
        logic [7:0]  exp_leds;
        ls = m_loss;
        hb = m_hb;
        exp_leds = {ls[1:0], 2'(m_state), m_grn, m_lk2, m_np2, hb[HB-1]};
        check("model_seq_state", 32'(bus.seq_state), m_state);
        check("model_global_reset_n", 32'(bus.global_reset_n), 32'(m_grn));
        check("model_leds", 32'(bus.leds), 32'(exp_leds));
    endtask

    task automatic tick();
        @(posedge config_clk);
        model_step();
        @(negedge config_clk);
        check_all();
    endtask

    // Advances until global_reset_n rises (bounded), recording the first cycle,
    // relative to the stimulus cycle 0, at which each state was observed.
    task automatic run_seq(input int start, input int max_len,
                           output int f_wait, output int f_hold, output int f_run);
        f_wait = -1; f_hold = -1; f_run = -1;
        for (int i = start + 1; i <= start + max_len; i++) begin
            tick();
            if (f_wait < 0 && bus.seq_state == 2'd1) f_wait = i;
            if (f_hold < 0 && bus.seq_state == 2'd2) f_hold = i;
            if (bus.global_reset_n === 1'b1) begin
                f_run = i;
                return;
            end
        end
    endtask

    task automatic settle_idle();
        bus.npor = 1'b0;
        bus.pll_locked = 1'b0;
        repeat (5) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.npor = 1'b0;
        bus.pll_locked = 1'b0;
        resetn = 1'b0;
        model_reset();

        // Reset state
        repeat (3) tick();
        check("reset_leds", 32'(bus.leds), 32'h0);
        check("reset_grst", 32'(bus.global_reset_n), 32'h0);
        resetn = 1'b1;
        tick();
        check("release_first_leds", 32'(bus.leds), 32'h0);
        check("release_first_state", 32'(bus.seq_state), 32'h0);
        $display("step reset: released, outputs idle");

        // Both inputs rise together in cycle 0
        bus.npor = 1'b1;
        bus.pll_locked = 1'b1;
        run_seq(0, 40, fw, fh, fr);
        check("rise_first_wait", fw, 3);
        check("rise_first_hold", fh, 7);
        check("rise_first_run", fr, LF + HC + 3);
        check("rise_run_state", 32'(bus.seq_state), 32'd3);
        $display("step power-up: wait=%0d hold=%0d run=%0d", fw, fh, fr);

        // Repeated lock loss from RUN; counter saturates at 3
        for (int k = 1; k <= 4; k++) begin
            bus.pll_locked = 1'b0;
            repeat (3) tick();
            check("loss_state_wait", 32'(bus.seq_state), 32'd1);
            check("loss_grst_low", 32'(bus.global_reset_n), 32'd0);
            check("loss_count", 32'(bus.leds[7:6]), (k > 3) ? 3 : k);
            bus.pll_locked = 1'b1;
            run_seq(0, 40, fw, fh, fr);
            check("relock_run", fr, LF + HC + 2);
            $display("step lock-loss %0d: leds=0x%0h relock run=%0d", k, bus.leds, fr);
        end

        // One-cycle lock glitch after three qualified cycles
        settle_idle();
        bus.npor = 1'b1;
        bus.pll_locked = 1'b1;
        repeat (4) tick();
        bus.pll_locked = 1'b0;
        tick();
        bus.pll_locked = 1'b1;
        run_seq(5, 40, fw, fh, fr);
        check("glitch_first_hold", fh, 11);
        check("glitch_first_run", fr, LF + HC + 3 + 4);
        check("glitch_loss_kept", 32'(bus.leds[7:6]), 32'd3);
        $display("step lock-glitch: hold=%0d run=%0d", fh, fr);

        // npor drops in HOLD at hold count 5
        settle_idle();
        bus.npor = 1'b1;
        bus.pll_locked = 1'b1;
        repeat (12) tick();
        check("npor_drop_in_hold", 32'(bus.seq_state), 32'd2);
        bus.npor = 1'b0;
        for (int i = 13; i <= 15; i++) begin
            tick();
            check("npor_drop_grst_low", 32'(bus.global_reset_n), 32'd0);
        end
        check("npor_drop_idle", 32'(bus.seq_state), 32'd0);
        bus.npor = 1'b1;
        run_seq(0, 40, fw, fh, fr);
        check("npor_return_hold", fh, 7);
        check("npor_return_run", fr, LF + HC + 3);
        $display("step npor-drop: return hold=%0d run=%0d", fh, fr);

        // Asynchronous reset mid-RUN, then heartbeat period
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        check("async_reset_grst", 32'(bus.global_reset_n), 32'd0);
        check("async_reset_state", 32'(bus.seq_state), 32'd0);
        check("async_reset_leds", 32'(bus.leds), 32'd0);
        repeat (2) tick();
        resetn = 1'b1;
        rise_at = -1;
        fall_at = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 1) check("async_release_first_leds", 32'(bus.leds), 32'd0);
            if (rise_at < 0 && bus.leds[0] === 1'b1) rise_at = i;
            if (rise_at >= 0 && fall_at < 0 && bus.leds[0] === 1'b0) fall_at = i;
        end
        check("heartbeat_rise", rise_at, 8);
        check("heartbeat_fall", fall_at, 16);
        $display("step async-reset: heartbeat rise=%0d fall=%0d", rise_at, fall_at);

        // Randomized inputs, including occasional reset pulses
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 23) == 0) bus.pll_locked = ~bus.pll_locked;
            if ($urandom_range(0, 79) == 0) bus.npor = ~bus.npor;
            resetn = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            tick();
        end
        resetn = 1'b1;
        $display("step random: 800 cycles, final state=%0d loss=%0d", bus.seq_state, bus.leds[7:6]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/board_reset_seq.md
BOARD_RESET_SEQ -- requirements
Module: board_reset_seq

Interface
REQ-001 Parameter HOLD_CYCLES, default 1024, is the number of cycles reset stays held after lock is qualified (legal range 2..2^20).
REQ-002 Parameter LOCK_FILTER, default 16, is the number of consecutive synchronized pll_locked-high cycles required to qualify lock (legal range 1..256).
REQ-003 Parameter HB_DIV_LOG2, default 25, selects the heartbeat bit of the free-running counter (legal range 2..32).
REQ-004 config_clk  input  1  sole clock, 50 MHz board configuration clock.
REQ-005 resetn  input  1  reset; asynchronous assertion, active-low.
REQ-006 npor  input  1  PCIe npor_out_reset_n from the system; asynchronous to config_clk.
REQ-007 pll_locked  input  1  kernel/DDR PLL lock indication; asynchronous to config_clk.
REQ-008 global_reset_n  output  1  registered active-low reset driving the system global_reset_reset_n input.
REQ-009 seq_state  output  2  current sequencer state encoding.
REQ-010 leds  output  8  board status LEDs.

Function
REQ-011 npor and pll_locked SHALL each pass through a two-flop synchronizer; the synchronized values are npor_s and locked_s.
REQ-012 States SHALL be IDLE=0, WAIT_LOCK=1, HOLD=2, RUN=3, output on seq_state.
REQ-013 Highest priority: npor_s=0 in any state SHALL force IDLE next cycle and clear both counters.
REQ-014 IDLE -> WAIT_LOCK when npor_s=1.
REQ-015 WAIT_LOCK: lock counter increments on each locked_s=1 cycle and clears on locked_s=0; at LOCK_FILTER consecutive high cycles the state SHALL go to HOLD.
REQ-016 HOLD: hold counter counts 0..HOLD_CYCLES-1; at terminal count the state SHALL go to RUN.
REQ-017 locked_s=0 in HOLD or RUN (with npor_s=1) SHALL go to WAIT_LOCK and clear both counters.
REQ-018 global_reset_n SHALL be a dedicated flop that is 1 exactly in cycles where the state is RUN; it SHALL never glitch.
REQ-019 Latency, both inputs rising in cycle 0 and held: global_reset_n=1 in cycle LOCK_FILTER+HOLD_CYCLES+3.
REQ-020 npor falling in cycle 0 SHALL give global_reset_n=0 no later than cycle 3.
REQ-021 A free-running counter of HB_DIV_LOG2 bits SHALL increment every cycle in all states and wrap to 0.
REQ-022 Lock-loss counter, 2 bits: increments on each REQ-017 transition, saturates at 3, cleared only by resetn.
REQ-023 leds mapping: [0] heartbeat (MSB of free-running counter), [1] npor_s, [2] locked_s, [3] global_reset_n, [5:4] state, [7:6] lock-loss count.
REQ-024 Simultaneous npor_s=0 and locked_s=0 SHALL resolve to IDLE without incrementing the lock-loss counter.

Reset
REQ-025 resetn=0 SHALL asynchronously clear all flops: state IDLE, synchronizers 0, all counters 0, global_reset_n 0, seq_state 0, leds 0.
REQ-026 Release of resetn SHALL restart the sequence from IDLE; no output SHALL change in the first cycle after release.

Structure
REQ-027 Package board_reset_pkg SHALL hold the state enum and the LED bit-index constants.
REQ-028 Sub-module reset_sync_2ff (two-flop synchronizer with async active-low clear) SHALL be instantiated once per asynchronous input.

Verification (LOCK_FILTER=4, HOLD_CYCLES=8, HB_DIV_LOG2=4)
REQ-029 Both inputs rise in cycle 0 -> global_reset_n=1 first in cycle 15; seq_state steps 0,1,2,3.
REQ-030 pll_locked glitches low for one cycle after 3 high cycles in WAIT_LOCK -> lock counter restarts; RUN is delayed by 4 cycles.
REQ-031 pll_locked falls while in RUN -> WAIT_LOCK, global_reset_n=0, leds[7:6]=1; four such events -> leds[7:6] stays 3.
REQ-032 npor falls in HOLD with hold count 5 -> IDLE within 3 cycles, counters 0; npor return repeats the full 15-cycle sequence.
REQ-033 resetn asserted mid-RUN -> all outputs 0 immediately (asynchronous); heartbeat leds[0] toggles every 8 cycles after release.
